// File: rtl/an_sec_serial_decoder.sv
// Bit-serial single-error-correcting decoder for AN arithmetic codes.
// Ports: clk/rst_n; in_valid/in_ready/in_code take a codeword; out_valid/out_ready return
//        out_code (corrected), out_loc (signed error position) and out_err (00 ok, 01 fixed, 10 bad).
// Latency N+k cycles from accept (k = matched position, 1 for no error, N when uncorrectable);
// one codeword in flight, the result is held until out_ready.
module an_sec_serial_decoder #(
   parameter int A  = 18613,
   parameter int N  = 45,
   parameter int RW = 15,
   parameter int LW = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_code,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_code,
   output logic signed [LW-1:0] out_loc,
   output logic [1:0]           out_err
);

   localparam int IW = $clog2(N + 1);
   localparam logic [RW:0] A_W = (RW+1)'(A);

   typedef enum logic [1:0] {IDLE, REDUCE, SEARCH, DONE} state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         code_q, code_d;
   logic [RW-1:0]        r_q, r_d;
   logic [RW-1:0]        p_q, p_d;
   logic [IW-1:0]        idx_q, idx_d;   // bit index in REDUCE, position i in SEARCH
   logic [N-1:0]         out_code_q, out_code_d;
   logic signed [LW-1:0] out_loc_q, out_loc_d;
   logic [1:0]           out_err_q, out_err_d;

   logic [RW:0]  t_w;      // 2r + bit, one bit wider than r
   logic [RW:0]  p2_w;     // 2p
   logic [RW:0]  neg_p_w;  // A - p, the residue of -2^(i-1)
   logic [N-1:0] onehot_w; // 2^(i-1)
   logic signed [LW-1:0] loc_w;

   assign t_w      = {r_q, code_q[idx_q]};
   assign p2_w     = {p_q, 1'b0};
   assign neg_p_w  = A_W - {1'b0, p_q};
   assign onehot_w = {{(N-1){1'b0}}, 1'b1} << (idx_q - IW'(1));
   assign loc_w    = LW'(idx_q);

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      r_d        = r_q;
      p_d        = p_q;
      idx_d      = idx_q;
      out_code_d = out_code_q;
      out_loc_d  = out_loc_q;
      out_err_d  = out_err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               code_d  = in_code;
               r_d     = '0;
               idx_d   = IW'(N - 1);
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            r_d = (t_w >= A_W) ? RW'(t_w - A_W) : RW'(t_w);
            if (idx_q == '0) begin
               p_d     = RW'(1);
               idx_d   = IW'(1);
               state_d = SEARCH;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         SEARCH: begin
            if (r_q == '0) begin
               out_code_d = code_q;
               out_loc_d  = '0;
               out_err_d  = 2'b00;
               state_d    = DONE;
            end else if (r_q == p_q) begin
               out_code_d = code_q - onehot_w;
               out_loc_d  = loc_w;
               out_err_d  = 2'b01;
               state_d    = DONE;
            end else if ({1'b0, r_q} == neg_p_w) begin
               out_code_d = code_q + onehot_w;
               out_loc_d  = -loc_w;
               out_err_d  = 2'b01;
               state_d    = DONE;
            end else if (idx_q == IW'(N)) begin
               out_code_d = code_q;
               out_loc_d  = '0;
               out_err_d  = 2'b10;
               state_d    = DONE;
            end else begin
               p_d   = (p2_w >= A_W) ? RW'(p2_w - A_W) : RW'(p2_w);
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         code_q     <= '0;
         r_q        <= '0;
         p_q        <= '0;
         idx_q      <= '0;
         out_code_q <= '0;
         out_loc_q  <= '0;
         out_err_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         r_q        <= r_d;
         p_q        <= p_d;
         idx_q      <= idx_d;
         out_code_q <= out_code_d;
         out_loc_q  <= out_loc_d;
         out_err_q  <= out_err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_code  = out_code_q;
   assign out_loc   = out_loc_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_an_sec_serial_decoder.sv
// Directed bench for an_sec_serial_decoder with A=18613, N=45 and codeword 5*A.
// Checks reset state, latency, corrected outputs, backpressure hold and mid-decode reset.
// Outputs are sampled 1ns after the rising edge; inputs change on the falling edge.
module tb_an_sec_serial_decoder;

   localparam int N  = 45;
   localparam int LW = 7;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [N-1:0]         in_code = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [N-1:0]         out_code;
   logic signed [LW-1:0] out_loc;
   logic [1:0]           out_err;

   int checks = 0;
   int failures = 0;

   an_sec_serial_decoder #(.A(18613), .N(45), .RW(15), .LW(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_loc   (out_loc),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Offers one codeword, waits for out_valid and checks result and latency.
   // When hold > 0, out_ready stays low for that many cycles in DONE first.
   task automatic decode(input string tag, input longint code, input longint exp_code,
                         input longint exp_loc, input longint exp_err, input int exp_lat,
                         input int hold);
      int lat;
      logic [N-1:0] held_code;
      @(negedge clk);
      in_code  = N'(code);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "_in_ready_busy"}, longint'(in_ready), 0);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1) lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_code"}, longint'(out_code), exp_code);
      check({tag, "_loc"}, longint'($signed(out_loc)), exp_loc);
      check({tag, "_err"}, longint'(out_err), exp_err);
      held_code = out_code;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         in_valid = 1'b1;          // must be ignored outside IDLE
         in_code  = N'(12345);
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, longint'(out_valid), 1);
         check({tag, "_hold_code"}, longint'(out_code), longint'(held_code));
         check({tag, "_hold_in_ready"}, longint'(in_ready), 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_valid_after_hs"}, longint'(out_valid), 0);
      check({tag, "_in_ready_after_hs"}, longint'(in_ready), 1);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_single_hs"}, longint'(out_valid), 0);
   endtask

   initial begin
      #2;
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_code", longint'(out_code), 0);
      check("rst_out_loc", longint'($signed(out_loc)), 0);
      check("rst_out_err", longint'(out_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      decode("noerr", 93065,  93065, 0,  0, 46, 0);
      decode("pos1",  93066,  93065, 1,  1, 46, 0);
      decode("pos15", 109449, 93065, 15, 1, 60, 0);
      decode("neg4",  93057,  93065, -4, 1, 49, 0);
      decode("uncor", 93068,  93068, 0,  2, 90, 0);
      decode("bp",    93066,  93065, 1,  1, 46, 5);

      // Reset in the middle of REDUCE; out_code still holds the last result.
      @(negedge clk);
      in_code  = N'(109449);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", longint'(in_ready), 1);
      check("mid_rst_out_valid", longint'(out_valid), 0);
      check("mid_rst_out_code", longint'(out_code), 0);
      check("mid_rst_out_loc", longint'($signed(out_loc)), 0);
      check("mid_rst_out_err", longint'(out_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      decode("after_rst", 93057, 93065, -4, 1, 49, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/an_sec_serial_decoder.md
# an_sec_serial_decoder

Parametrised, sequential single-error-correcting decoder for AN arithmetic codes. It accepts an N-bit codeword, reduces it modulo A bit-serially, and searches the signed single-error residues ±2^(i-1) mod A one position per cycle. It outputs the corrected codeword, the signed error location and an error status. It replaces fixed, per-configuration residue lookup tables: changing A and N needs no new table. It sits between a codeword store and the data consumer, with valid/ready handshakes on both sides.

## Interface
- A, default 18613: code multiplier; must be odd and > 2.
- N, default 45: codeword width in bits; error positions are 1..N.
- RW, default 15: remainder width, ceil(log2(A)).
- LW, default 7: signed location width; must hold ±N.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  codeword offered.
- in_ready  output  1  decoder can accept; high only in IDLE.
- in_code  input  N  received codeword.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_code  output  N  corrected codeword.
- out_loc  output  LW (signed)  +i: error added 2^(i-1); -i: error subtracted 2^(i-1); 0: no error located.
- out_err  output  2  00 no error, 01 corrected, 10 uncorrectable; 11 is never driven.

## Operation
- States: IDLE, REDUCE, SEARCH, DONE.
- IDLE: in_ready=1.
  - in_valid && in_ready → latch code=in_code, r=0, bit=N-1; go to REDUCE.
- REDUCE: one bit per cycle, MSB first, for N cycles.
  - t = 2r + code[bit], computed in RW+1 bits.
  - r = (t ≥ A) ? t−A : t.
  - After bit 0 is processed: p=1, i=1; go to SEARCH.
- SEARCH: one cycle per candidate position. Priority within each cycle:
  1. r==0 → loc=0, err=00, out_code=code.
  2. r==p → loc=+i, err=01, out_code=(code − 2^(i−1)) mod 2^N.
  3. r==A−p → loc=−i, err=01, out_code=(code + 2^(i−1)) mod 2^N.
  4. No match and i==N → loc=0, err=10, out_code=code (unmodified).
  5. Otherwise: p = (2p ≥ A) ? 2p−A : 2p; i=i+1; stay in SEARCH.
  - Cases 1–4 go to DONE.
- Conditions 2 and 3 are mutually exclusive because A is odd.
- If A aliases two positions, the lowest i wins, with + before −.
- DONE: out_valid=1. Outputs are held stable until out_ready=1, then the decoder returns to IDLE.
- No overlap: a new codeword is accepted only after the result handshake completes.
- All modular arithmetic stays below A; no intermediate value exceeds RW+1 bits.

## Timing
- Reset (asynchronous assert, any state): state=IDLE. Outputs: in_ready=1, out_valid=0, out_code=0, out_loc=0, out_err=00. All internal registers are cleared and an in-flight codeword is discarded.
- Reset release is taken synchronously on clk.
- Accept edge E0 is the edge with in_valid && in_ready. REDUCE occupies edges E1..EN.
- SEARCH at match index k (k=1 for no error) resolves on edge EN+k. out_valid rises after edge EN+k.
- Latency from accept to out_valid is N+k cycles:
  - no error: N+1
  - error at position ±i: N+i
  - uncorrectable: 2N
- in_ready drops on the cycle after E0 and stays low until the cycle after the out handshake edge.
- The output handshake completes on the edge where out_valid && out_ready. out_valid is low in the next cycle.
- in_valid is ignored outside IDLE. in_code is sampled only at E0.

## Test plan
Defaults A=18613, N=45; codeword C = 5·A = 93065.
- No error: in_code=93065 → out_code=93065, out_loc=0, out_err=00, out_valid at 46 cycles.
- Positive error at position 1: in_code=93066 (r=1) → out_code=93065, out_loc=+1, out_err=01, latency 46.
- Positive error at position 15: in_code=93065+16384=109449 → out_code=93065, out_loc=+15, out_err=01, latency 60.
- Negative error at position 4: in_code=93057 (r=18605) → out_code=93065, out_loc=−4, out_err=01, latency 49.
- Uncorrectable: in_code=93068 (r=3) → out_code=93068, out_loc=0, out_err=10, latency 90.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout. Releasing out_ready → exactly one handshake.
  - Assert rst_n=0 mid-REDUCE → immediate IDLE with all outputs at reset values. The next codeword then decodes correctly.
